// File: rtl/alien_spawner_pkg.sv
// alien_spawner shared types and defaults.
// FSM encoding plus the default sizing of the spawner.
package alien_spawner_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PICK  = 2'd1,
      S_OFFER = 2'd2
   } state_t;

   localparam int DEF_SPAWN_PERIOD = 1000;
   localparam int DEF_MAX_ALIENS   = 8;
   localparam int DEF_SLOT_W       = 3;
   localparam int DEF_COL_W        = 4;

endpackage

// File: rtl/alien_spawner_lowest_free_slot.sv
// Priority encoder: lowest zero bit of the occupancy map,
// with a same-cycle kill already folded in.
module lowest_free_slot
   import alien_spawner_pkg::*;
#(
   parameter int MAX_ALIENS = DEF_MAX_ALIENS,
   parameter int SLOT_W     = DEF_SLOT_W
) (
   input  logic [MAX_ALIENS-1:0] active,
   input  logic                  kill,
   input  logic [SLOT_W-1:0]     kill_slot,
   output logic [SLOT_W-1:0]     slot,
   output logic                  none_free
);

   logic [MAX_ALIENS-1:0] live;

   always_comb begin
      live = active;
      if (kill)
         live[kill_slot] = 1'b0;
      slot      = '0;
      none_free = 1'b1;
      // scan downward so the lowest free index wins
      for (int i = MAX_ALIENS - 1; i >= 0; i--) begin
         if (!live[i]) begin
            slot      = SLOT_W'(i);
            none_free = 1'b0;
         end
      end
   end

endmodule

// File: rtl/alien_spawner.sv
// Paces spawn attempts, picks a non-repeating column and the
// lowest free slot, and offers it over valid/ready.
module alien_spawner
   import alien_spawner_pkg::*;
#(
   parameter int SPAWN_PERIOD = DEF_SPAWN_PERIOD,
   parameter int MAX_ALIENS   = DEF_MAX_ALIENS,
   parameter int SLOT_W       = DEF_SLOT_W,
   parameter int COL_W        = DEF_COL_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [15:0]           rnd,
   input  logic                  kill,
   input  logic [SLOT_W-1:0]     kill_slot,
   input  logic                  spawn_ready,
   output logic                  spawn_valid,
   output logic [SLOT_W-1:0]     spawn_slot,
   output logic [COL_W-1:0]      spawn_x,
   output logic [MAX_ALIENS-1:0] active,
   output logic                  drop
);

   localparam int TMR_W = (SPAWN_PERIOD > 2) ? $clog2(SPAWN_PERIOD) : 1;
   localparam logic [TMR_W-1:0] RELOAD = TMR_W'(SPAWN_PERIOD - 1);
   localparam logic [MAX_ALIENS-1:0] ONE = MAX_ALIENS'(1);

   state_t                state_q, state_d;
   logic [TMR_W-1:0]      timer_q, timer_d;
   logic [SLOT_W-1:0]     slot_q, slot_d;
   logic [COL_W-1:0]      x_q, x_d;
   logic [COL_W-1:0]      last_x_q, last_x_d;
   logic [MAX_ALIENS-1:0] active_q, active_d;
   logic                  drop_q, drop_d;

   logic [SLOT_W-1:0]     free_slot;
   logic                  none_free;
   logic [COL_W-1:0]      cand, pick_x;
   logic [MAX_ALIENS-1:0] kill_mask, set_mask;
   logic                  unused_rnd;

   assign unused_rnd = ^rnd[15:COL_W];

   lowest_free_slot #(
      .MAX_ALIENS (MAX_ALIENS),
      .SLOT_W     (SLOT_W)
   ) u_free (
      .active    (active_q),
      .kill      (kill),
      .kill_slot (kill_slot),
      .slot      (free_slot),
      .none_free (none_free)
   );

   // bump by one on a repeat; natural wrap of COL_W bits
   assign cand   = rnd[COL_W-1:0];
   assign pick_x = (cand == last_x_q) ? cand + COL_W'(1) : cand;

   assign kill_mask = kill ? (ONE << kill_slot) : '0;
   assign set_mask  = ONE << slot_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         timer_q  <= RELOAD;
         slot_q   <= '0;
         x_q      <= '0;
         last_x_q <= '0;
         active_q <= '0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         slot_q   <= slot_d;
         x_q      <= x_d;
         last_x_q <= last_x_d;
         active_q <= active_d;
         drop_q   <= drop_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      slot_d   = slot_q;
      x_d      = x_q;
      last_x_d = last_x_q;
      drop_d   = 1'b0;
      active_d = active_q & ~kill_mask;
      unique case (state_q)
         S_IDLE: begin
            if (enable) begin
               if (timer_q == '0)
                  state_d = S_PICK;
               else
                  timer_d = timer_q - TMR_W'(1);
            end
         end
         S_PICK: begin
            x_d = pick_x;
            if (none_free) begin
               drop_d  = 1'b1;
               timer_d = RELOAD;
               state_d = S_IDLE;
            end else begin
               slot_d  = free_slot;
               state_d = S_OFFER;
            end
         end
         S_OFFER: begin
            if (spawn_ready) begin
               active_d = active_d | set_mask;
               last_x_d = x_q;
               timer_d  = RELOAD;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign spawn_valid = (state_q == S_OFFER);
   assign spawn_slot  = slot_q;
   assign spawn_x     = x_q;
   assign active      = active_q;
   assign drop        = drop_q;

endmodule

// File: tb/tb_alien_spawner.sv
// Directed bench for alien_spawner with SPAWN_PERIOD=4; offers
// are checked by a scoreboard monitor at each handshake.
module tb_alien_spawner;

   localparam int P  = 4;
   localparam int SW = 3;
   localparam int CW = 4;
   localparam int NA = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic [15:0]   rnd;
   logic          kill;
   logic [SW-1:0] kill_slot;
   logic          spawn_ready;
   logic          spawn_valid;
   logic [SW-1:0] spawn_slot;
   logic [CW-1:0] spawn_x;
   logic [NA-1:0] active;
   logic          drop;

   int compared   = 0;
   int mismatched = 0;
   logic [SW+CW-1:0] exp_q[$];

   alien_spawner #(
      .SPAWN_PERIOD (P),
      .MAX_ALIENS   (NA),
      .SLOT_W       (SW),
      .COL_W        (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .rnd         (rnd),
      .kill        (kill),
      .kill_slot   (kill_slot),
      .spawn_ready (spawn_ready),
      .spawn_valid (spawn_valid),
      .spawn_slot  (spawn_slot),
      .spawn_x     (spawn_x),
      .active      (active),
      .drop        (drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_offer(input int max_e, output int n);
      n = 0;
      while (!spawn_valid && n < max_e) begin
         step();
         n++;
      end
      chk("offer_seen", 32'(spawn_valid), 32'd1);
   endtask

   task automatic attempt(input logic [15:0] r, input logic [SW-1:0] s,
                          input logic [CW-1:0] x, input logic [NA-1:0] a);
      int n;
      rnd = r;
      exp_q.push_back({s, x});
      wait_offer(20, n);
      chk("latency", 32'(n), 32'(P + 1));
      step();
      chk("active_after", 32'(active), 32'(a));
      chk("valid_low", 32'(spawn_valid), 32'd0);
   endtask

   always @(negedge clk) begin
      if (!reset && spawn_valid && spawn_ready) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_offer: got slot %0d x %0d expected none",
                     spawn_slot, spawn_x);
         end else begin
            logic [SW+CW-1:0] e;
            e = exp_q.pop_front();
            chk("offer_slot", 32'(spawn_slot), 32'(e[SW+CW-1:CW]));
            chk("offer_x", 32'(spawn_x), 32'(e[CW-1:0]));
         end
      end
   end

   initial begin
      int n;
      reset = 1'b1; enable = 1'b1; rnd = 16'h0005;
      spawn_ready = 1'b1; kill = 1'b0; kill_slot = '0;
      step(); step();
      chk("rst_valid", 32'(spawn_valid), 32'd0);
      chk("rst_slot", 32'(spawn_slot), 32'd0);
      chk("rst_x", 32'(spawn_x), 32'd0);
      chk("rst_active", 32'(active), 32'd0);
      chk("rst_drop", 32'(drop), 32'd0);

      exp_q.push_back({3'd0, 4'd5});
      reset = 1'b0;
      for (int e = 1; e <= P + 1; e++) begin
         step();
         if (e <= P)
            chk("pre_valid", 32'(spawn_valid), 32'd0);
      end
      chk("first_valid", 32'(spawn_valid), 32'd1);
      step();
      chk("active_first", 32'(active), 32'h01);

      attempt(16'hA3C5, 3'd1, 4'd6,  8'h03);
      attempt(16'h000F, 3'd2, 4'd15, 8'h07);
      attempt(16'h000F, 3'd3, 4'd0,  8'h0F);
      attempt(16'h0001, 3'd4, 4'd1,  8'h1F);
      attempt(16'h0002, 3'd5, 4'd2,  8'h3F);
      attempt(16'h0003, 3'd6, 4'd3,  8'h7F);
      attempt(16'h0004, 3'd7, 4'd4,  8'hFF);

      rnd = 16'h0005;
      for (int e = 1; e <= 10; e++) begin
         step();
         chk("drop_pulse", 32'(drop), 32'((e == 5) || (e == 10)));
         chk("drop_novalid", 32'(spawn_valid), 32'd0);
      end
      chk("full_active", 32'(active), 32'hFF);

      kill = 1'b1; kill_slot = 3'd2;
      step();
      kill = 1'b0;
      chk("kill2", 32'(active), 32'hFB);
      rnd = 16'h0007;
      spawn_ready = 1'b0;
      exp_q.push_back({3'd2, 4'd7});
      wait_offer(20, n);
      chk("lat_after_drop", 32'(n), 32'd4);

      for (int c = 0; c < 20; c++) begin
         enable = (c % 2 == 1);
         rnd = 16'(c * 37 + 1);
         kill = (c == 5);
         kill_slot = 3'd0;
         step();
         chk("hold_valid", 32'(spawn_valid), 32'd1);
         chk("hold_slot", 32'(spawn_slot), 32'd2);
         chk("hold_x", 32'(spawn_x), 32'd7);
      end
      kill = 1'b0;
      chk("hold_active", 32'(active), 32'hFA);
      enable = 1'b1;
      spawn_ready = 1'b1;
      step();
      chk("after_hold", 32'(active), 32'hFE);
      chk("after_hold_v", 32'(spawn_valid), 32'd0);

      spawn_ready = 1'b0;
      rnd = 16'h0009;
      enable = 1'b0;
      for (int e = 0; e < 10; e++) begin
         step();
         chk("paused", 32'(spawn_valid), 32'd0);
      end
      enable = 1'b1;
      wait_offer(20, n);
      chk("lat_pause", 32'(n), 32'(P + 1));
      chk("pend_slot", 32'(spawn_slot), 32'd0);
      chk("pend_x", 32'(spawn_x), 32'd9);

      #2 reset = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(spawn_valid), 32'd0);
      chk("mid_rst_active", 32'(active), 32'd0);
      chk("mid_rst_x", 32'(spawn_x), 32'd0);
      step(); step();
      rnd = 16'h0003;
      spawn_ready = 1'b1;
      exp_q.push_back({3'd0, 4'd3});
      reset = 1'b0;
      wait_offer(20, n);
      chk("lat_rst", 32'(n), 32'(P + 1));
      step();
      chk("active_rst", 32'(active), 32'h01);

      step();
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
